serv_rf_bank_ctrl: RTL and testbench
====================================

// Module: serv_rf_bank_ctrl
// PURPOSE
//  Banked register-file controller between serv_rf_ram_if and serv_rf_ram.
//  Generalises the fixed 4-bank, ibus[31:30]-selected RF to NUM_BANKS banks with any WIDTH.
//  Each write is tagged with the bank that was active when the write was captured.
//  Adds a read-after-write bypass and an error pulse for out-of-range bank selects.
//  The RAM always sees a single flat address of {bank, word}.
// PARAMETERS
//  WIDTH      2     RF port width in bits (1,2,4,8,16,32)
//  CSR_REGS   4     extra CSR registers stored in the RF (0 or 4)
//  NUM_BANKS  4     number of register banks (>=1, need not be a power of 2)
//  BANK_LSB   30    LSB of the bank-select field in the ibus address
//  L2D        $clog2((32+CSR_REGS)*32/WIDTH)   word-address width per bank
//  BANK_W     (NUM_BANKS>1) ? $clog2(NUM_BANKS) : 1   bank index width
// PORTS
//  clk          in   1             clock
//  i_rst        in   1             asynchronous active-high reset
//  i_ibus_adr   in   32            instruction fetch address
//  i_ibus_ack   in   1             fetch ack; bank is sampled on this
//  i_waddr      in   L2D           write word address from rf_ram_if
//  i_wdata      in   WIDTH         write data from rf_ram_if
//  i_wen        in   1             write enable from rf_ram_if
//  i_raddr      in   L2D           read word address from rf_ram_if
//  o_rdata      out  WIDTH         read data to rf_ram_if, 1-cycle latency
//  o_ram_waddr  out  BANK_W+L2D    RAM write address {bank,word}
//  o_ram_wdata  out  WIDTH         RAM write data
//  o_ram_wen    out  1             RAM write enable
//  o_ram_raddr  out  BANK_W+L2D    RAM read address {bank,word}
//  i_ram_rdata  in   WIDTH         RAM read data, 1-cycle latency
//  o_bank       out  BANK_W        currently active bank
//  o_bank_err   out  1             1-cycle pulse: requested bank >= NUM_BANKS
//  o_ready      out  1             controller ready; rf_ram_if must hold requests until high
// BEHAVIOUR
//  Reset values: bank=0, o_bank_err=0, o_ram_wen=0, o_ready=0, bypass valid=0, o_rdata=0.
//  Bank select: sel = i_ibus_adr[BANK_LSB +: BANK_W].
//   On i_ibus_ack with sel < NUM_BANKS: bank <= sel, visible on o_bank the next cycle.
//   On i_ibus_ack with sel >= NUM_BANKS: bank holds and o_bank_err=1 for exactly 1 cycle.
//  Write path: one register stage. {bank,i_waddr}, i_wdata and i_wen are captured together.
//   o_ram_* are driven from that stage, so a write issued in cycle N commits in cycle N+1.
//   The commit goes to the bank held in cycle N, even if bank changes in cycle N+1.
//  Read path: o_ram_raddr={bank,i_raddr} combinationally; o_rdata = i_ram_rdata (1 cycle).
//  Bypass: when o_ram_wen=1 and o_ram_waddr equals o_ram_raddr in the same cycle, the
//   next cycle o_rdata = the registered write data instead of i_ram_rdata (RAM read-first).
//  With NUM_BANKS=1, the bank field is a constant 0 and o_bank_err never asserts.
//  FSM states: RST -> RUN, or RST -> CLR -> RUN (see CONFIGURATION).
//   o_ready=1 only in RUN.
//   Assertion of i_rst from any state returns to RST immediately (asynchronous).
//   An in-flight write stage is dropped on reset (o_ram_wen cleared).
//  Requests with o_ready=0 are ignored: i_wen is masked and no bank update is made.
// CONFIGURATION
//  SERV_RF_BANK_CLEAR_EN defined:
//   After reset release, the CLR state sweeps addresses 0 .. NUM_BANKS*2^L2D-1.
//   Sweep writes zero with o_ram_wen=1, one address per cycle; then RUN.
//   o_ready rises the cycle after the last clear write.
//  SERV_RF_BANK_CLEAR_EN undefined:
//   RST -> RUN on the first clock after reset release; no clear writes are issued.
// STRUCTURE
//  Package serv_rf_bank_pkg holds:
//   the state enum {RST,CLR,RUN};
//   a function rf_l2d(width,csr_regs);
//   a function bank_w(num_banks).
//  Sub-module serv_rf_bank_sel: bank register, range check and o_bank_err pulse.
//  Write stage, bypass and FSM live in the top body.
// TESTING
//  1. Reset then idle, macro undefined -> o_ready=0 during reset, 1 on the first clk after
//     release; no o_ram_wen.
//  2. ack with adr=0xC000_0000 (NUM_BANKS=4) -> o_bank=3 next cycle.
//     Write waddr=5 -> o_ram_waddr={3,5} one cycle later.
//  3. Write to {0,7} in cycle N with ack adr=0x4000_0000 in cycle N ->
//     commit at {0,7} in N+1; o_bank=1 from N+1.
//  4. NUM_BANKS=3, ack adr=0xC000_0000 -> o_bank_err high for 1 cycle, o_bank unchanged.
//  5. Write wdata=2'b10 to word 9 while reading word 9 in the commit cycle ->
//     o_rdata=2'b10 next cycle.
//  6. Macro defined, NUM_BANKS=2, WIDTH=32, CSR_REGS=0 (L2D=5) ->
//     64 zero writes, o_ready rises on cycle 65.
//     Reset mid-sweep restarts the sweep from 0.

Source files
------------

// File: rtl/serv_rf_bank_pkg.sv
// Shared types and sizing helpers for the banked SERV register-file controller.
package serv_rf_bank_pkg;

  // Controller FSM: RST holds everything idle, CLR sweeps the RAM, RUN serves requests.
  typedef enum logic [1:0] {
    RST = 2'd0,
    CLR = 2'd1,
    RUN = 2'd2
  } state_t;

  // Word-address width of one bank: GPRs plus CSRs, 32 bits each, WIDTH bits per word.
  function automatic int rf_l2d(input int width, input int csr_regs);
    return $clog2((32 + csr_regs) * 32 / width);
  endfunction

  // Bank index width; a single bank still carries a 1-bit (constant zero) field.
  function automatic int bank_w(input int num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 1;
  endfunction

endpackage

// File: rtl/serv_rf_bank_sel.sv
// Bank-select register: latches the requested bank on an accepted fetch ack and
// raises a one-cycle error pulse when the requested bank does not exist.
module serv_rf_bank_sel
  import serv_rf_bank_pkg::*;
#(
  parameter int NUM_BANKS = 4,
  parameter int BANK_W    = bank_w(NUM_BANKS)
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic [BANK_W-1:0] i_sel,
  output logic [BANK_W-1:0] o_bank,
  output logic              o_bank_err
);

  localparam logic [BANK_W:0] NB = NUM_BANKS[BANK_W:0];

  logic              sel_ok;
  logic              sel_bad;
  logic [BANK_W-1:0] bank_q;
  logic              err_q;

  // With a single bank the field is pinned to zero and never flagged.
  assign sel_ok  = (NUM_BANKS > 1) && ({1'b0, i_sel} < NB);
  assign sel_bad = (NUM_BANKS > 1) && !sel_ok;

  // Bank register and error pulse; an out-of-range request leaves the bank untouched.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      bank_q <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= i_en & sel_bad;
      if (i_en && sel_ok) begin
        bank_q <= i_sel;
      end
    end
  end

  assign o_bank     = bank_q;
  assign o_bank_err = err_q;

endmodule

// File: rtl/serv_rf_bank_ctrl.sv
// Banked register-file controller sitting between serv_rf_ram_if and serv_rf_ram.
// The RAM sees one flat address {bank, word}. Writes pass through one register
// stage tagged with the bank active at capture; a read of the address being
// committed in the same cycle is served from the write stage on the next cycle.
// Optional feature macro: SERV_RF_BANK_CLEAR_EN -- when defined, the whole RAM is
// swept with zeros after reset release before the controller reports ready.
module serv_rf_bank_ctrl
  import serv_rf_bank_pkg::*;
#(
  parameter int WIDTH     = 2,
  parameter int CSR_REGS  = 4,
  parameter int NUM_BANKS = 4,
  parameter int BANK_LSB  = 30,
  parameter int L2D       = rf_l2d(WIDTH, CSR_REGS),
  parameter int BANK_W    = bank_w(NUM_BANKS)
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic [31:0]           i_ibus_adr,
  input  logic                  i_ibus_ack,
  input  logic [L2D-1:0]        i_waddr,
  input  logic [WIDTH-1:0]      i_wdata,
  input  logic                  i_wen,
  input  logic [L2D-1:0]        i_raddr,
  output logic [WIDTH-1:0]      o_rdata,
  output logic [BANK_W+L2D-1:0] o_ram_waddr,
  output logic [WIDTH-1:0]      o_ram_wdata,
  output logic                  o_ram_wen,
  output logic [BANK_W+L2D-1:0] o_ram_raddr,
  input  logic [WIDTH-1:0]      i_ram_rdata,
  output logic [BANK_W-1:0]     o_bank,
  output logic                  o_bank_err,
  output logic                  o_ready
);

  localparam int AW = BANK_W + L2D;

  state_t            state;
  state_t            state_nxt;
  logic              clr_active;
  logic              clr_done;
  logic [AW-1:0]     clr_cnt;
  logic [BANK_W-1:0] bank;
  logic [BANK_W-1:0] sel;
  logic              unused_adr;

  logic              wr_vld_p1;
  logic [AW-1:0]     wr_addr_p1;
  logic [WIDTH-1:0]  wr_data_p1;
  logic              byp_vld_p2;
  logic [WIDTH-1:0]  byp_data_p2;

  assign sel        = i_ibus_adr[BANK_LSB +: BANK_W];
  assign unused_adr = ^i_ibus_adr;

  serv_rf_bank_sel #(
    .NUM_BANKS (NUM_BANKS),
    .BANK_W    (BANK_W)
  ) u_bank_sel (
    .clk        (clk),
    .i_rst      (i_rst),
    .i_en       (i_ibus_ack & o_ready),
    .i_sel      (sel),
    .o_bank     (bank),
    .o_bank_err (o_bank_err)
  );

  assign o_bank = bank;

`ifdef SERV_RF_BANK_CLEAR_EN
  localparam bit            CLR_EN     = 1'b1;
  localparam int            CLR_LAST_I = NUM_BANKS * (2 ** L2D) - 1;
  localparam logic [AW-1:0] CLR_LAST   = CLR_LAST_I[AW-1:0];

  // Sweep address: advances once per CLR cycle, restarts from zero outside CLR.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      clr_cnt <= '0;
    end else if (state == CLR) begin
      clr_cnt <= clr_cnt + 1'b1;
    end else begin
      clr_cnt <= '0;
    end
  end

  assign clr_done = (clr_cnt == CLR_LAST);
`else
  localparam bit CLR_EN = 1'b0;

  assign clr_cnt  = '0;
  assign clr_done = 1'b1;
`endif

  // FSM state register; reset forces RST from any state.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state <= RST;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: optional clear sweep between reset and normal operation.
  always_comb begin
    state_nxt = state;
    case (state)
      RST:     state_nxt = CLR_EN ? CLR : RUN;
      CLR:     if (clr_done) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = RST;
    endcase
  end

  // FSM outputs: requests are only accepted in RUN.
  always_comb begin
    o_ready    = 1'b0;
    clr_active = 1'b0;
    case (state)
      CLR:     clr_active = 1'b1;
      RUN:     o_ready    = 1'b1;
      default: ;
    endcase
  end

  // ---- stage p1: write capture ----
  // Write-stage valid; requests arriving while not ready are dropped here.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      wr_vld_p1 <= 1'b0;
    end else begin
      wr_vld_p1 <= i_wen & o_ready;
    end
  end

  // Write-stage payload, tagged with the bank active in the capture cycle.
  always_ff @(posedge clk) begin
    wr_addr_p1 <= {bank, i_waddr};
    wr_data_p1 <= i_wdata;
  end

  assign o_ram_wen   = clr_active | wr_vld_p1;
  assign o_ram_waddr = clr_active ? clr_cnt : wr_addr_p1;
  assign o_ram_wdata = clr_active ? '0 : wr_data_p1;
  assign o_ram_raddr = {bank, i_raddr};

  // ---- stage p2: read-after-write bypass ----
  // Bypass valid: the RAM is read-first, so a same-cycle hit must come from the write stage.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      byp_vld_p2 <= 1'b0;
    end else begin
      byp_vld_p2 <= o_ram_wen && (o_ram_waddr == o_ram_raddr);
    end
  end

  // Bypass data: the value committed alongside the hit.
  always_ff @(posedge clk) begin
    byp_data_p2 <= o_ram_wdata;
  end

  assign o_rdata = byp_vld_p2 ? byp_data_p2 : (o_ready ? i_ram_rdata : '0);

endmodule

// File: tb/tb_serv_rf_bank_ctrl.sv
// Testbench for serv_rf_bank_ctrl: a 4-bank instance backed by a read-first RAM
// model, plus a 3-bank instance for out-of-range bank selects.
module tb_serv_rf_bank_ctrl;

  localparam int WIDTH  = 2;
  localparam int L2D    = $clog2((32 + 4) * 32 / WIDTH);
  localparam int BANK_W = 2;
  localparam int AW     = BANK_W + L2D;

  logic              clk = 1'b0;
  logic              i_rst;
  logic [31:0]       i_ibus_adr;
  logic              i_ibus_ack;
  logic [L2D-1:0]    i_waddr;
  logic [WIDTH-1:0]  i_wdata;
  logic              i_wen;
  logic [L2D-1:0]    i_raddr;
  logic [WIDTH-1:0]  o_rdata;
  logic [AW-1:0]     o_ram_waddr;
  logic [WIDTH-1:0]  o_ram_wdata;
  logic              o_ram_wen;
  logic [AW-1:0]     o_ram_raddr;
  logic [WIDTH-1:0]  ram_rdata;
  logic [BANK_W-1:0] o_bank;
  logic              o_bank_err;
  logic              o_ready;

  logic [WIDTH-1:0]  zero_rd = '0;
  logic [WIDTH-1:0]  unused3_rdata;
  logic [AW-1:0]     unused3_waddr;
  logic [WIDTH-1:0]  unused3_wdata;
  logic              unused3_wen;
  logic [AW-1:0]     unused3_raddr;
  logic              unused3_ready;
  logic [BANK_W-1:0] bank3;
  logic              bank3_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serv_rf_bank_ctrl #(.WIDTH(2), .CSR_REGS(4), .NUM_BANKS(4), .BANK_LSB(30)) dut (
    .clk(clk), .i_rst(i_rst), .i_ibus_adr(i_ibus_adr), .i_ibus_ack(i_ibus_ack),
    .i_waddr(i_waddr), .i_wdata(i_wdata), .i_wen(i_wen), .i_raddr(i_raddr),
    .o_rdata(o_rdata), .o_ram_waddr(o_ram_waddr), .o_ram_wdata(o_ram_wdata),
    .o_ram_wen(o_ram_wen), .o_ram_raddr(o_ram_raddr), .i_ram_rdata(ram_rdata),
    .o_bank(o_bank), .o_bank_err(o_bank_err), .o_ready(o_ready)
  );

  serv_rf_bank_ctrl #(.WIDTH(2), .CSR_REGS(4), .NUM_BANKS(3), .BANK_LSB(30)) dut3 (
    .clk(clk), .i_rst(i_rst), .i_ibus_adr(i_ibus_adr), .i_ibus_ack(i_ibus_ack),
    .i_waddr(i_waddr), .i_wdata(i_wdata), .i_wen(i_wen), .i_raddr(i_raddr),
    .o_rdata(unused3_rdata), .o_ram_waddr(unused3_waddr), .o_ram_wdata(unused3_wdata),
    .o_ram_wen(unused3_wen), .o_ram_raddr(unused3_raddr), .i_ram_rdata(zero_rd),
    .o_bank(bank3), .o_bank_err(bank3_err), .o_ready(unused3_ready)
  );

  // Read-first RAM with one cycle of read latency
  logic [WIDTH-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (o_ram_wen) ram[o_ram_waddr] <= o_ram_wdata;
    ram_rdata <= ram[o_ram_raddr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_ibus_ack = 1'b0;
    i_ibus_adr = 32'h0;
    i_wen      = 1'b0;
    i_waddr    = '0;
    i_wdata    = '0;
    i_raddr    = '0;
  endtask

  task automatic test_reset();
    int cyc;
    int nwen;
    int bad;
    int exp_wen;
    i_rst = 1'b1;
    idle_inputs();
    repeat (3) tick();
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", o_ready); end
    checks++; if (o_ram_wen !== 1'b0) begin errors++; $display("FAIL reset_wen got %b exp 0", o_ram_wen); end
    checks++; if (o_bank !== 2'd0) begin errors++; $display("FAIL reset_bank got %0d exp 0", o_bank); end
    checks++; if (o_bank_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", o_bank_err); end
    checks++; if (o_rdata !== 2'd0) begin errors++; $display("FAIL reset_rdata got %0d exp 0", o_rdata); end
    // Requests offered while not ready must be ignored
    i_rst      = 1'b0;
    i_wen      = 1'b1;
    i_waddr    = 10'd3;
    i_ibus_ack = 1'b1;
    i_ibus_adr = 32'hC000_0000;
    cyc = 0; nwen = 0; bad = 0;
    while (o_ready !== 1'b1 && cyc < 20000) begin
      tick();
      cyc++;
      idle_inputs();
      if (o_ram_wen === 1'b1) begin
        if (o_ram_waddr !== nwen[AW-1:0] || o_ram_wdata !== 2'd0) bad++;
        nwen++;
      end
    end
`ifdef SERV_RF_BANK_CLEAR_EN
    exp_wen = 4 * (1 << L2D);
`else
    exp_wen = 0;
`endif
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL ready_rise got %b exp 1", o_ready); end
    checks++; if (cyc != exp_wen + 1) begin errors++; $display("FAIL ready_cycle got %0d exp %0d", cyc, exp_wen + 1); end
    checks++; if (nwen != exp_wen) begin errors++; $display("FAIL clear_writes got %0d exp %0d", nwen, exp_wen); end
    checks++; if (bad != 0) begin errors++; $display("FAIL clear_sequence got %0d bad exp 0", bad); end
    checks++; if (o_bank !== 2'd0) begin errors++; $display("FAIL masked_ack_bank got %0d exp 0", o_bank); end
  endtask

`ifdef SERV_RF_BANK_CLEAR_EN
  task automatic test_clear_restart();
    int cyc;
    repeat (10) tick();
    i_rst = 1'b1;
    tick();
    checks++; if (o_ram_wen !== 1'b0) begin errors++; $display("FAIL restart_reset_wen got %b exp 0", o_ram_wen); end
    i_rst = 1'b0;
    tick();
    checks++; if (o_ram_wen !== 1'b1 || o_ram_waddr !== '0) begin
      errors++; $display("FAIL restart_first got wen=%b addr=%0d exp wen=1 addr=0", o_ram_wen, o_ram_waddr);
    end
    cyc = 0;
    while (o_ready !== 1'b1 && cyc < 20000) begin tick(); cyc++; end
    checks++; if (cyc != 4 * (1 << L2D)) begin errors++; $display("FAIL restart_ready got %0d exp %0d", cyc, 4 * (1 << L2D)); end
  endtask
`endif

  task automatic test_bank_select();
    i_ibus_ack = 1'b1;
    i_ibus_adr = 32'hC000_0000;
    tick();
    idle_inputs();
    checks++; if (o_bank !== 2'd3) begin errors++; $display("FAIL sel_bank got %0d exp 3", o_bank); end
    checks++; if (o_bank_err !== 1'b0) begin errors++; $display("FAIL sel_err got %b exp 0", o_bank_err); end
    checks++; if (bank3_err !== 1'b1 || bank3 !== 2'd0) begin
      errors++; $display("FAIL sel3_err got err=%b bank=%0d exp err=1 bank=0", bank3_err, bank3);
    end
    i_wen = 1'b1; i_waddr = 10'd5; i_wdata = 2'b01;
    tick();
    idle_inputs();
    checks++; if (o_ram_wen !== 1'b1 || o_ram_waddr !== {2'd3, 10'd5} || o_ram_wdata !== 2'b01) begin
      errors++; $display("FAIL sel_write got wen=%b addr=%h data=%b exp wen=1 addr=%h data=01",
                         o_ram_wen, o_ram_waddr, o_ram_wdata, {2'd3, 10'd5});
    end
    checks++; if (bank3_err !== 1'b0) begin errors++; $display("FAIL sel3_pulse got %b exp 0", bank3_err); end
    tick();
    checks++; if (o_ram_wen !== 1'b0) begin errors++; $display("FAIL sel_single_write got %b exp 0", o_ram_wen); end
  endtask

  task automatic test_write_bank_change();
    i_ibus_ack = 1'b1; i_ibus_adr = 32'h0;
    tick();
    idle_inputs();
    checks++; if (o_bank !== 2'd0) begin errors++; $display("FAIL chg_bank0 got %0d exp 0", o_bank); end
    i_wen = 1'b1; i_waddr = 10'd7; i_wdata = 2'b11;
    i_ibus_ack = 1'b1; i_ibus_adr = 32'h4000_0000;
    tick();
    idle_inputs();
    checks++; if (o_ram_wen !== 1'b1 || o_ram_waddr !== {2'd0, 10'd7}) begin
      errors++; $display("FAIL chg_commit got wen=%b addr=%h exp wen=1 addr=%h", o_ram_wen, o_ram_waddr, {2'd0, 10'd7});
    end
    checks++; if (o_bank !== 2'd1) begin errors++; $display("FAIL chg_bank1 got %0d exp 1", o_bank); end
  endtask

  task automatic test_bank_err();
    logic [31:0] r;
    r = $urandom;
    i_ibus_ack = 1'b1;
    i_ibus_adr = {2'b11, r[29:0]};
    tick();
    idle_inputs();
    checks++; if (bank3_err !== 1'b1) begin errors++; $display("FAIL err_pulse got %b exp 1", bank3_err); end
    checks++; if (bank3 !== 2'd1) begin errors++; $display("FAIL err_hold got %0d exp 1", bank3); end
    checks++; if (o_bank !== 2'd3 || o_bank_err !== 1'b0) begin
      errors++; $display("FAIL err_4bank got bank=%0d err=%b exp bank=3 err=0", o_bank, o_bank_err);
    end
    tick();
    checks++; if (bank3_err !== 1'b0 || bank3 !== 2'd1) begin
      errors++; $display("FAIL err_end got err=%b bank=%0d exp err=0 bank=1", bank3_err, bank3);
    end
  endtask

  task automatic test_bypass();
    i_wen = 1'b1; i_waddr = 10'd9; i_wdata = 2'b01;
    tick();
    idle_inputs();
    tick();
    tick();
    // Cycle N: new write, and a read of the same word sees the old value
    i_wen = 1'b1; i_waddr = 10'd9; i_wdata = 2'b10; i_raddr = 10'd9;
    tick();
    idle_inputs();
    checks++; if (o_rdata !== 2'b01) begin errors++; $display("FAIL byp_old got %b exp 01", o_rdata); end
    // Commit cycle: read of the word being committed
    i_raddr = 10'd9;
    tick();
    checks++; if (o_rdata !== 2'b10) begin errors++; $display("FAIL byp_hit got %b exp 10", o_rdata); end
    tick();
    checks++; if (o_rdata !== 2'b10) begin errors++; $display("FAIL byp_ram got %b exp 10", o_rdata); end
    idle_inputs();
  endtask

  task automatic test_random();
    logic [1:0]    ref_mem [0:3][0:15];
    logic [1:0]    mbank;
    logic [1:0]    s;
    logic [1:0]    exp_rd;
    logic [AW-1:0] exp_waddr;
    logic [1:0]    exp_wdata;
    logic          exp_wen;
    logic [31:0]   r;
    mbank = 2'd0;
    // Fill banks 0..3, words 0..15 with known values
    for (int b = 0; b < 4; b++) begin
      s = 2'(b);
      i_ibus_ack = 1'b1; i_ibus_adr = {s, 30'h0}; i_wen = 1'b0;
      tick();
      i_ibus_ack = 1'b0;
      mbank = s;
      for (int w = 0; w < 16; w++) begin
        i_wen = 1'b1; i_waddr = 10'(w); i_wdata = 2'($urandom_range(3));
        ref_mem[mbank][w] = i_wdata;
        tick();
      end
    end
    for (int i = 0; i < 400; i++) begin
      r = $urandom;
      s = 2'($urandom_range(3));
      i_ibus_ack = ($urandom_range(3) == 0);
      i_ibus_adr = {s, r[29:0]};
      i_wen   = 1'($urandom_range(1));
      i_waddr = 10'($urandom_range(15));
      i_wdata = 2'($urandom_range(3));
      i_raddr = 10'($urandom_range(15));
      exp_rd    = ref_mem[mbank][i_raddr[3:0]];
      exp_wen   = i_wen;
      exp_waddr = {mbank, i_waddr};
      exp_wdata = i_wdata;
      if (i_wen) ref_mem[mbank][i_waddr[3:0]] = i_wdata;
      if (i_ibus_ack) mbank = s;
      tick();
      checks++; if (o_rdata !== exp_rd) begin errors++; $display("FAIL rnd_rdata[%0d] got %b exp %b", i, o_rdata, exp_rd); end
      checks++; if (o_bank !== mbank) begin errors++; $display("FAIL rnd_bank[%0d] got %0d exp %0d", i, o_bank, mbank); end
      checks++; if (o_ram_wen !== exp_wen) begin errors++; $display("FAIL rnd_wen[%0d] got %b exp %b", i, o_ram_wen, exp_wen); end
      if (exp_wen) begin
        checks++; if (o_ram_waddr !== exp_waddr || o_ram_wdata !== exp_wdata) begin
          errors++; $display("FAIL rnd_write[%0d] got addr=%h data=%b exp addr=%h data=%b",
                             i, o_ram_waddr, o_ram_wdata, exp_waddr, exp_wdata);
        end
      end
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b1;
    idle_inputs();
    test_reset();
`ifdef SERV_RF_BANK_CLEAR_EN
    test_clear_restart();
`endif
    test_bank_select();
    test_write_bank_change();
    test_bank_err();
    test_bypass();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
